// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack controller between fetch/decode and the RAS.
// Build option: define RAS_COMPRESSED_EN to also decode C.JAL/C.JALR/C.JR.
module ras_ctrl #(
    parameter int XLEN = 32,
    parameter int SIZE = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            push_o,
    output logic            pop_o,
    output logic [XLEN-1:0] data_o,
    input  logic [XLEN-1:0] stack_top_i,
    input  logic            overflow_i,
    output logic            pred_valid_o,
    output logic            pred_hit_o,
    output logic [XLEN-1:0] pred_target_o
);

    // WAIT marks the cycle after a return was held back because the stack
    // top was still updating; the held return is accepted in that cycle.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PRED
    } state_t;

    localparam logic [SIZE:0] DEPTH_MAX = {1'b1, {SIZE{1'b0}}};
    localparam logic [SIZE:0] DEPTH_ONE = {{SIZE{1'b0}}, 1'b1};

    state_t          r_state;
    logic [SIZE:0]   r_depth;
    logic            r_settled;
    logic            r_hit;
    logic [XLEN-1:0] r_target;

    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic       w_rd_lnk;
    logic       w_rs1_lnk;
    logic       w_jal;
    logic       w_jalr;
    logic       w_call;
    logic       w_ret;
    logic       w_co;
    logic       w_half;
    logic       w_ret_any;
    logic       w_stall;
    logic       w_xfer;
    logic       w_unused;

    assign w_rd      = instr_i[11:7];
    assign w_rs1     = instr_i[19:15];
    assign w_rd_lnk  = (w_rd == 5'd1) || (w_rd == 5'd5);
    assign w_rs1_lnk = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    assign w_jal     = (instr_i[6:0] == 7'b1101111);
    assign w_jalr    = (instr_i[6:0] == 7'b1100111)
                    && (instr_i[14:12] == 3'b000);
    assign w_unused  = ^{instr_i[XLEN-1:20]};

    // Classify the offered instruction from its link-register hints
    always_comb begin
        w_call = 1'b0;
        w_ret  = 1'b0;
        w_co   = 1'b0;
        w_half = 1'b0;
        if (instr_i[1:0] == 2'b11) begin
            if (w_jal) begin
                w_call = w_rd_lnk;
            end else if (w_jalr) begin
                w_co   = w_rd_lnk && w_rs1_lnk && (w_rd != w_rs1);
                w_call = w_rd_lnk && !(w_rs1_lnk && (w_rd != w_rs1));
                w_ret  = w_rs1_lnk && !w_rd_lnk;
            end
        end
`ifdef RAS_COMPRESSED_EN
        else begin
            w_half = 1'b1;
            if ((XLEN == 32) && (instr_i[1:0] == 2'b01)
                && (instr_i[15:13] == 3'b001)) begin
                w_call = 1'b1;
            end else if ((instr_i[1:0] == 2'b10)
                && (instr_i[6:2] == 5'd0) && (w_rd != 5'd0)) begin
                if (instr_i[15:12] == 4'b1001) begin
                    w_co   = (w_rd == 5'd5);
                    w_call = (w_rd != 5'd5);
                end else if (instr_i[15:12] == 4'b1000) begin
                    w_ret = w_rd_lnk;
                end
            end
        end
`endif
    end

    // A return may only be taken once stack_top_i has caught up
    assign w_ret_any = w_ret || w_co;
    assign w_stall   = valid_i && w_ret_any && !r_settled;
    assign ready_o   = !flush_i && !w_stall;
    assign w_xfer    = valid_i && ready_o && !rst_i;

    assign push_o = w_xfer && (w_call || w_co);
    assign pop_o  = w_xfer && w_ret_any;
    assign data_o = push_o
                  ? pc_i + (w_half ? XLEN'(2) : XLEN'(4))
                  : '0;

    assign pred_valid_o  = (r_state == PRED) && !flush_i;
    assign pred_hit_o    = r_hit;
    assign pred_target_o = r_target;

    // Mirror the stack pointer and note when the stack top is in flux
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_depth   <= '0;
            r_settled <= 1'b1;
        end else begin
            r_settled <= !(push_o || pop_o);
            if (push_o && !pop_o) begin
                if (r_depth != DEPTH_MAX) begin
                    r_depth <= r_depth + DEPTH_ONE;
                end
            end else if (pop_o && !push_o) begin
                if (r_depth != '0) begin
                    r_depth <= r_depth - DEPTH_ONE;
                end
            end else if (push_o && pop_o) begin
                if (r_depth == '0) begin
                    r_depth <= DEPTH_ONE;
                end
            end
        end
    end

    // Prediction FSM: latch the stack top when a return is taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_hit    <= 1'b0;
            r_target <= '0;
        end else if (flush_i) begin
            r_state <= IDLE;
        end else if (w_stall) begin
            r_state <= WAIT;
        end else if (pop_o) begin
            r_state  <= PRED;
            r_target <= stack_top_i;
            r_hit    <= (r_depth != '0) && !overflow_i;
        end else begin
            r_state <= IDLE;
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: scoreboard bench for ras_ctrl with a behavioural stack.
// Directed call/return scenarios followed by randomized traffic.
module tb_ras_ctrl;

    localparam int DEPTH = 128;

    typedef enum int { K_OTH, K_CALL, K_RET, K_CO } kind_e;
    typedef struct {
        bit          hit;
        logic [31:0] tgt;
        int          cyc;
    } pred_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        push_o;
    logic        pop_o;
    logic [31:0] data_o;
    logic [31:0] stack_top_i = '0;
    logic        overflow_i = 1'b0;
    logic        pred_valid_o;
    logic        pred_hit_o;
    logic [31:0] pred_target_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    bit          chk_en = 0;
    bit          in_rst = 0;
    logic        exp_ready = 1'b1;
    logic        exp_push = 1'b0;
    logic        exp_pop = 1'b0;
    logic [31:0] exp_data = '0;
    bit          acc = 0;
    bit          last_op = 0;

    pred_t       sb[$];
    pred_t       pend;
    bit          pend_v = 0;
    logic [31:0] mq[$];
    bit          movf = 0;

    logic [31:0] emu[$];
    bit          emu_ovf = 0;

    ras_ctrl #(.XLEN(32), .SIZE(7)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .push_o       (push_o),
        .pop_o        (pop_o),
        .data_o       (data_o),
        .stack_top_i  (stack_top_i),
        .overflow_i   (overflow_i),
        .pred_valid_o (pred_valid_o),
        .pred_hit_o   (pred_hit_o),
        .pred_target_o(pred_target_o)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream stack: keeps the newest DEPTH entries, flags overflow
    initial forever begin
        @(posedge clk);
        if (rst_i) begin
            emu.delete();
            emu_ovf = 0;
        end else if (push_o && pop_o) begin
            if (emu.size() != 0) emu[emu.size()-1] = data_o;
            else emu.push_back(data_o);
        end else if (push_o) begin
            if (emu.size() == DEPTH) begin
                void'(emu.pop_front());
                emu_ovf = 1;
            end
            emu.push_back(data_o);
        end else if (pop_o) begin
            if (emu.size() != 0) void'(emu.pop_back());
            emu_ovf = 0;
        end
        stack_top_i <= (emu.size() != 0) ? emu[$] : 32'h0;
        overflow_i  <= emu_ovf;
    end

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic bit lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic kind_e kind_of(input logic [31:0] w,
                                      output int len);
        logic [4:0] rd;
        logic [4:0] rs;
        rd  = w[11:7];
        rs  = w[19:15];
        len = 4;
        if (w[1:0] == 2'b11) begin
            if (w[6:0] == 7'h6F) return lnk(rd) ? K_CALL : K_OTH;
            if (w[6:0] != 7'h67 || w[14:12] != 3'b000) return K_OTH;
            if (lnk(rd) && lnk(rs) && rd != rs) return K_CO;
            if (lnk(rd)) return K_CALL;
            return lnk(rs) ? K_RET : K_OTH;
        end
        len = 2;
`ifdef RAS_COMPRESSED_EN
        if (w[1:0] == 2'b01 && w[15:13] == 3'b001) return K_CALL;
        if (w[1:0] == 2'b10 && w[6:2] == 5'd0 && rd != 5'd0) begin
            if (w[15:12] == 4'b1001) return (rd == 5'd5) ? K_CO : K_CALL;
            if (w[15:12] == 4'b1000 && lnk(rd)) return K_RET;
        end
`endif
        return K_OTH;
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'h0, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd,
                                         input logic [4:0] rs1);
        return {12'h0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [4:0]  a;
        logic [4:0]  b;
        r = $urandom;
        a = rreg();
        b = rreg();
        case ($urandom_range(0, 7))
            0, 1: return {r[31:12], a, 7'h6F};
            2, 3: return {r[31:20], b, 3'b000, a, 7'h67};
            4: return {r[31:20], b, 3'(r[2:0] | 3'b001), a, 7'h67};
            5: return {r[31:16], 3'b001, r[12:2], 2'b01};
            6: return {r[31:16], 3'b100, r[0], a, 5'd0, 2'b10};
            default: return {r[31:7], 7'h13};
        endcase
    endfunction

    // One driven cycle; the reference decides acceptance and expectations
    task automatic step(input bit v, input logic [31:0] ins,
                        input logic [31:0] pc, input bit fl);
        kind_e k;
        int    len;
        bit    stall;
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        valid_i = v;
        instr_i = ins;
        pc_i    = pc;
        flush_i = fl;
        if (pend_v && !fl) sb.push_back(pend);
        pend_v = 0;
        k = kind_of(ins, len);
        stall = v && (k == K_RET || k == K_CO) && last_op;
        exp_ready = !fl && !stall;
        acc = v && exp_ready;
        exp_push = acc && (k == K_CALL || k == K_CO);
        exp_pop  = acc && (k == K_RET || k == K_CO);
        exp_data = exp_push ? pc + 32'(len) : 32'h0;
        if (exp_pop) begin
            pend.hit = (mq.size() != 0) && !movf;
            pend.tgt = (mq.size() != 0) ? mq[$] : 32'h0;
            pend.cyc = cyc + 1;
            pend_v   = 1;
        end
        if (acc) begin
            case (k)
                K_CALL: begin
                    if (mq.size() == DEPTH) begin
                        void'(mq.pop_front());
                        movf = 1;
                    end
                    mq.push_back(exp_data);
                end
                K_RET: begin
                    if (mq.size() != 0) void'(mq.pop_back());
                    movf = 0;
                end
                K_CO: begin
                    if (mq.size() != 0) mq[mq.size()-1] = exp_data;
                    else mq.push_back(exp_data);
                end
                default: ;
            endcase
        end
        last_op = exp_push || exp_pop;
        in_rst  = 0;
        chk_en  = 1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        int tries;
        tries = 0;
        do begin
            step(1, ins, pc, 0);
            tries++;
        end while (!acc && tries < 3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_i   = 1'b1;
            valid_i = 1'b0;
            flush_i = 1'b0;
            instr_i = '0;
            pc_i    = '0;
            sb.delete();
            mq.delete();
            pend_v    = 0;
            movf      = 0;
            last_op   = 0;
            exp_ready = 1'b1;
            exp_push  = 1'b0;
            exp_pop   = 1'b0;
            exp_data  = '0;
            in_rst    = (i > 0);
            chk_en    = (i > 0);
        end
    endtask

    // Monitor: per-cycle handshake checks and prediction scoreboard
    initial forever begin
        pred_t e;
        @(negedge clk);
        if (chk_en) begin
            chk("ready_o", 32'(ready_o), 32'(exp_ready));
            chk("push_o", 32'(push_o), 32'(exp_push));
            chk("pop_o", 32'(pop_o), 32'(exp_pop));
            chk("data_o", data_o, exp_data);
            if (in_rst) begin
                chk("rst_pred_hit", 32'(pred_hit_o), 32'h0);
                chk("rst_pred_target", pred_target_o, 32'h0);
            end
            if (sb.size() != 0 && sb[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pred_missing: got none expected cycle %0d",
                         sb[0].cyc);
                void'(sb.pop_front());
            end
            if (pred_valid_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pred_unexpected: got valid expected none (cycle %0d)",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pred_cycle", cyc, e.cyc);
                    chk("pred_hit", 32'(pred_hit_o), 32'(e.hit));
                    if (e.hit) chk("pred_target", pred_target_o, e.tgt);
                end
            end
        end
    end

    initial begin
        int r;
        bit v;
        do_reset(3);
        offer(jal(5'd1), 32'h100);
        idle(1);
        offer(jalr(5'd0, 5'd1), 32'h180);
        idle(2);
        offer(jal(5'd1), 32'h100);
        offer(jalr(5'd0, 5'd1), 32'h140);
        idle(2);
        do_reset(2);
        offer(jalr(5'd0, 5'd5), 32'h300);
        offer(jalr(5'd0, 5'd1), 32'h304);
        idle(1);
        for (int i = 0; i < DEPTH + 1; i++) offer(jal(5'd5), 32'h1000 + 32'(4 * i));
        idle(1);
        offer(jalr(5'd0, 5'd5), 32'h2000);
        idle(1);
        offer(jalr(5'd0, 5'd1), 32'h2004);
        idle(1);
        do_reset(2);
        offer(jal(5'd1), 32'h500);
        idle(1);
        offer(jalr(5'd0, 5'd1), 32'h540);
        step(0, 32'h0, 32'h0, 1);
        idle(2);
        offer(32'h0000_2001, 32'h200);
        idle(1);
        offer(32'h0000_8082, 32'h204);
        idle(1);
        offer(jalr(5'd1, 5'd5), 32'h600);
        offer(jalr(5'd5, 5'd5), 32'h700);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle(2);
                do_reset(2);
            end
            r = $urandom_range(0, 99);
            v = 1'($urandom_range(0, 1));
            if (r < 10) step(0, rnd_instr(), $urandom & ~32'h1, 0);
            else if (r < 16) step(v, rnd_instr(), $urandom & ~32'h1, 1);
            else offer(rnd_instr(), $urandom & ~32'h1);
        end
        idle(4);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pred_leftover: got %0d outstanding expected 0",
                     sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
